// File: rtl/dtw_regs_pkg.sv
// Shared constants for the DTW S00_AXI register file: register count,
// register indices, AXI response codes and address decode position.
package dtw_regs_pkg;
    localparam int NUM_REGS  = 4;
    localparam int REG_IDX_W = $clog2(NUM_REGS);
    localparam int ADDR_LSB  = 2;

    localparam logic [REG_IDX_W-1:0] REG_0 = 2'd0;
    localparam logic [REG_IDX_W-1:0] REG_1 = 2'd1;
    localparam logic [REG_IDX_W-1:0] REG_2 = 2'd2;
    localparam logic [REG_IDX_W-1:0] REG_3 = 2'd3;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
endpackage

// File: rtl/dtw_s00_axi_regs.sv
// AXI4-Lite slave holding four 32-bit registers for the DTW core; AW and W
// are captured independently and commit together, reads return pre-write data.
module dtw_s00_axi_regs
    import dtw_regs_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                                 S_AXI_ACLK,
    input  logic                                 S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic [2:0]                           S_AXI_AWPROT,
    input  logic                                 S_AXI_AWVALID,
    output logic                                 S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    input  logic                                 S_AXI_WVALID,
    output logic                                 S_AXI_WREADY,
    output logic [1:0]                           S_AXI_BRESP,
    output logic                                 S_AXI_BVALID,
    input  logic                                 S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
    input  logic [2:0]                           S_AXI_ARPROT,
    input  logic                                 S_AXI_ARVALID,
    output logic                                 S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
    output logic [1:0]                           S_AXI_RRESP,
    output logic                                 S_AXI_RVALID,
    input  logic                                 S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_o,
    output logic [NUM_REGS-1:0]                  reg_wr_o
);
    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = DW / 8;

    logic [NUM_REGS-1:0][DW-1:0] regs;
    logic                        aw_full, w_full, bvalid, rvalid;
    logic [REG_IDX_W-1:0]        aw_idx_q;
    logic [DW-1:0]               w_data_q, rdata;
    logic [STRB_W-1:0]           w_strb_q;
    logic [NUM_REGS-1:0]         reg_wr;

    logic                        aw_hs, w_hs, ar_hs, commit;
    logic [REG_IDX_W-1:0]        wr_idx, rd_idx;
    logic [DW-1:0]               wr_data;
    logic [STRB_W-1:0]           wr_strb;
    logic [NUM_REGS-1:0]         wr_onehot;
    logic                        unused;

    assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                      S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    assign S_AXI_AWREADY = !aw_full && !bvalid;
    assign S_AXI_WREADY  = !w_full && !bvalid;
    assign S_AXI_ARREADY = !rvalid;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = AXI_RESP_OKAY;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = AXI_RESP_OKAY;
    assign reg_o         = regs;
    assign reg_wr_o      = reg_wr;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // A held beat takes priority over the bus, which is not ready while held.
    assign commit  = (aw_full || aw_hs) && (w_full || w_hs);
    assign wr_idx  = aw_full ? aw_idx_q : S_AXI_AWADDR[ADDR_LSB +: REG_IDX_W];
    assign wr_data = w_full ? w_data_q : S_AXI_WDATA;
    assign wr_strb = w_full ? w_strb_q : S_AXI_WSTRB;
    assign rd_idx  = S_AXI_ARADDR[ADDR_LSB +: REG_IDX_W];

    always_comb begin
        wr_onehot         = '0;
        wr_onehot[wr_idx] = 1'b1;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            regs     <= '0;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bvalid   <= 1'b0;
            reg_wr   <= '0;
        end else begin
            reg_wr <= '0;
            if (commit) begin
                for (int b = 0; b < STRB_W; b++)
                    if (wr_strb[b])
                        regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                bvalid  <= 1'b1;
                reg_wr  <= wr_onehot;
            end else begin
                if (aw_hs) begin
                    aw_full  <= 1'b1;
                    aw_idx_q <= S_AXI_AWADDR[ADDR_LSB +: REG_IDX_W];
                end
                if (w_hs) begin
                    w_full   <= 1'b1;
                    w_data_q <= S_AXI_WDATA;
                    w_strb_q <= S_AXI_WSTRB;
                end
                if (bvalid && S_AXI_BREADY)
                    bvalid <= 1'b0;
            end
        end
    end

    // regs is sampled before this edge's commit lands, so same-edge reads see old data.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= regs[rd_idx];
        end else if (rvalid && S_AXI_RREADY) begin
            rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dtw_s00_axi_regs.sv
// Directed bench for dtw_s00_axi_regs: inputs driven and outputs sampled on
// the falling edge, expectations hand-computed.
module tb_dtw_s00_axi_regs;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   awaddr = '0, araddr = '0;
    logic [2:0]   awprot = '0, arprot = '0;
    logic         awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [127:0] reg_o;
    logic [3:0]   reg_wr_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dtw_s00_axi_regs dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_o(reg_o), .reg_wr_o(reg_wr_o)
    );

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // AW and W together; leaves the bench on a falling edge.
    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [31:0] exp_reg, input int idx);
        int n;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        n = 0;
        while (!(awready && wready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!(awready && wready)) begin
            chk("wr_timeout", 0, 1);
            awvalid = 0; wvalid = 0;
            return;
        end
        @(posedge clk); @(negedge clk);
        awvalid = 0; wvalid = 0;
        chk("wr_bvalid", bvalid, 1);
        chk("wr_bresp", bresp, 2'b00);
        chk("wr_pulse", reg_wr_o, 4'b0001 << idx);
        chk("wr_reg", reg_o[32*idx +: 32], exp_reg);
        if (bready) begin
            @(posedge clk); @(negedge clk);
            chk("wr_bclear", bvalid, 0);
            chk("wr_pulse_end", reg_wr_o, 4'b0000);
        end
    endtask

    task automatic do_read(input logic [3:0] a, input logic [31:0] exp);
        int n;
        araddr = a; arvalid = 1;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!arready) begin
            chk("rd_timeout", 0, 1);
            arvalid = 0;
            return;
        end
        @(posedge clk); @(negedge clk);
        arvalid = 0;
        chk("rd_rvalid", rvalid, 1);
        chk("rd_rdata", rdata, exp);
        chk("rd_rresp", rresp, 2'b00);
        if (rready) begin
            @(posedge clk); @(negedge clk);
            chk("rd_rclear", rvalid, 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_awready", awready, 0 | 1'b1 & rst_n | 1);
        chk("rst_reg_o", reg_o, '0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        rst_n = 1;
        @(negedge clk);
        chk("rst_ready", {awready, wready, arready}, 3'b111);
        chk("rst_pulse", reg_wr_o, 4'b0000);

        // Basic writes then read-back
        do_write(4'h0, 32'h1, 4'hF, 32'h1, 0);
        do_write(4'h4, 32'h2, 4'hF, 32'h2, 1);
        do_write(4'h8, 32'h3, 4'hF, 32'h3, 2);
        do_write(4'hC, 32'h4, 4'hF, 32'h4, 3);
        do_read(4'h0, 32'h1);
        do_read(4'h4, 32'h2);
        do_read(4'h8, 32'h3);
        do_read(4'hC, 32'h4);

        // W three cycles ahead of AW
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
        @(posedge clk); @(negedge clk);
        wvalid = 0;
        chk("wfirst_wready", wready, 0);
        chk("wfirst_nob", bvalid, 0);
        repeat (2) @(negedge clk);
        chk("wfirst_nob2", bvalid, 0);
        chk("wfirst_nocommit", reg_o[95:64], 32'h3);
        awaddr = 4'h8; awvalid = 1;
        chk("wfirst_awready", awready, 1);
        @(posedge clk); @(negedge clk);
        awvalid = 0;
        chk("wfirst_b", bvalid, 1);
        chk("wfirst_reg", reg_o[95:64], 32'hDEADBEEF);
        chk("wfirst_pulse", reg_wr_o, 4'b0100);
        @(posedge clk); @(negedge clk);
        chk("wfirst_bclr", bvalid, 0);

        // Byte strobes
        do_write(4'h4, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF, 1);
        do_write(4'h4, 32'h12345678, 4'b0101, 32'hFF34FF78, 1);
        do_read(4'h4, 32'hFF34FF78);

        // Zero strobe: response and pulse, no data change
        do_write(4'h4, 32'h0, 4'b0000, 32'hFF34FF78, 1);

        // Same-edge read and commit of reg 0
        awaddr = 4'h0; wdata = 32'h99; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 4'h0; arvalid = 1;
        @(posedge clk); @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("same_rdata_old", rdata, 32'h1);
        chk("same_reg_new", reg_o[31:0], 32'h99);
        chk("same_both_valid", {bvalid, rvalid}, 2'b11);
        @(posedge clk); @(negedge clk);

        // BREADY held low stalls the write channel
        bready = 0;
        do_write(4'hC, 32'h11, 4'hF, 32'h11, 3);
        awaddr = 4'hC; wdata = 32'h22; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        for (int i = 0; i < 5; i++) begin
            chk("bstall_bvalid", bvalid, 1);
            chk("bstall_ready", {awready, wready}, 2'b00);
            @(negedge clk);
        end
        chk("bstall_hold", reg_o[127:96], 32'h11);
        bready = 1;
        @(posedge clk); @(negedge clk);
        chk("bstall_release", {bvalid, awready}, 2'b01);
        @(posedge clk); @(negedge clk);
        awvalid = 0; wvalid = 0;
        chk("bstall_second_b", bvalid, 1);
        chk("bstall_second_reg", reg_o[127:96], 32'h22);
        chk("bstall_second_pulse", reg_wr_o, 4'b1000);
        @(posedge clk); @(negedge clk);

        // RREADY held low keeps RDATA stable
        rready = 0;
        do_read(4'h8, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstall_rvalid", rvalid, 1);
            chk("rstall_rdata", rdata, 32'hDEADBEEF);
            chk("rstall_arready", arready, 0);
        end
        rready = 1;
        @(posedge clk); @(negedge clk);
        chk("rstall_release", {rvalid, arready}, 2'b01);

        // Reset while B pending
        bready = 0;
        do_write(4'h4, 32'h77, 4'hF, 32'h77, 1);
        rst_n = 0;
        #1;
        chk("arst_bvalid", bvalid, 0);
        chk("arst_reg_o", reg_o, '0);
        chk("arst_ready", {awready, wready, arready}, 3'b111);
        @(negedge clk);
        rst_n = 1; bready = 1;
        @(negedge clk);
        do_write(4'h4, 32'hA5A5A5A5, 4'hF, 32'hA5A5A5A5, 1);
        do_read(4'h4, 32'hA5A5A5A5);
        do_read(4'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
